// File: rtl/mem_arbiter.sv
// Byte-wide RAM port controller: arbitrates instruction fetch against load/store
// and sequences each access as 1, 2 or 4 little-endian byte transfers.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic              we_q, we_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  // lost: a byte arrived while paused; skip: din is stale after re-presenting.
  logic              lost_q, lost_d;
  logic              skip_q, skip_d;

  logic [2:0]        ls_len;
  logic [1:0]        byte_idx;

  always_comb begin
    unique case (ls_size)
      2'd0:    ls_len = 3'd1;
      2'd1:    ls_len = 3'd2;
      default: ls_len = 3'd4;
    endcase
  end

  // Byte captured this cycle belongs to the address issued one step earlier.
  assign byte_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    we_d       = we_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    lost_d     = lost_q;
    skip_d     = skip_q;
    if_ack     = 1'b0;
    ls_ack     = 1'b0;

    if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (ls_req || (if_req && !flush)) begin
            owner_ls_d = ls_req;
            we_d       = ls_req & ls_we;
            addr_d     = ls_req ? ls_addr : if_addr;
            len_d      = ls_req ? ls_len : 3'd4;
            cnt_d      = 3'd0;
            rbuf_d     = '0;
            lost_d     = 1'b0;
            skip_d     = 1'b0;
            ram_a_d    = addr_d;
            if (ls_req && ls_we) begin
              ram_dout_d = ls_wdata[7:0];
              wdata_d    = ls_wdata >> 8;
              state_d    = StWrite;
            end else begin
              state_d    = StRead;
            end
          end
        end
        StRead: begin
          if (flush && !owner_ls_q) begin
            state_d = StIdle;
          end else if (lost_q) begin
            cnt_d   = cnt_q - 3'd1;
            ram_a_d = addr_q + ADDR_W'(cnt_q - 3'd1);
            skip_d  = 1'b1;
            lost_d  = 1'b0;
          end else begin
            skip_d = 1'b0;
            if (cnt_q != 3'd0 && !skip_q) begin
              rbuf_d[{byte_idx, 3'b000} +: 8] = ram_din;
            end
            if (cnt_q == len_q) begin
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q + 3'd1 < len_q) begin
                ram_a_d = ram_a_q + ADDR_W'(1);
              end
            end
          end
        end
        StWrite: begin
          if (cnt_q + 3'd1 == len_q) begin
            state_d = StDone;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            ram_a_d    = ram_a_q + ADDR_W'(1);
            ram_dout_d = wdata_q[7:0];
            wdata_d    = wdata_q >> 8;
          end
        end
        StDone: begin
          state_d = StIdle;
          if (owner_ls_q) begin
            ls_ack = 1'b1;
            if (!we_q) begin
              ls_rdata_d = rbuf_q;
            end
          end else if (!flush) begin
            if_ack    = 1'b1;
            if_data_d = rbuf_q;
          end
        end
      endcase
    end else if (state_q == StRead && cnt_q != 3'd0) begin
      lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      we_q       <= 1'b0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'h00;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      lost_q     <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      we_q       <= we_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      ram_a_q    <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      lost_q     <= lost_d;
      skip_q     <= skip_d;
    end
  end

  assign ram_a    = ram_a_q;
  assign ram_dout = ram_dout_q;
  assign ram_wr   = rdy && (state_q == StWrite);
  assign if_data  = if_ack ? rbuf_q : if_data_q;
  assign ls_rdata = (ls_ack && !we_q) ? rbuf_q : ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected acks and
// RAM writes; a negedge monitor pops and compares when the DUT presents them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_ack;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [int unsigned];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) ram_din <= rd_byte(ram_a);

  int checks = 0;
  int failures = 0;
  int if_acks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit          is_ls;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } ack_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  ack_exp_t ack_q[$];
  wr_exp_t  wr_q[$];

  always @(negedge clk) begin
    ack_exp_t ea;
    wr_exp_t  ew;
    if (rst_n) begin
      if (if_ack || ls_ack) begin
        if (if_ack) if_acks++;
        if (ack_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got if_ack=%0b ls_ack=%0b at cycle %0d, required none",
                   if_ack, ls_ack, cyc);
        end else begin
          ea = ack_q.pop_front();
          check("ack_owner", {31'b0, ls_ack}, {31'b0, ea.is_ls});
          if (ea.cyc >= 0) check("ack_cycle", cyc, ea.cyc);
          if (ea.chk_data) check("ack_data", ea.is_ls ? ls_rdata : if_data, ea.data);
        end
      end
      if (ram_wr) begin
        if (wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %h data %h at cycle %0d, required none",
                   ram_a, ram_dout, cyc);
        end else begin
          ew = wr_q.pop_front();
          check("wr_addr", ram_a, ew.addr);
          check("wr_data", {24'b0, ram_dout}, {24'b0, ew.data});
          check("wr_cycle", cyc, ew.cyc);
        end
      end
      if (!rdy) check("wr_while_paused", {31'b0, ram_wr}, 32'h0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_ack(input bit is_ls, input bit chk, input logic [31:0] d, input int c);
    ack_exp_t e;
    e.is_ls = is_ls; e.chk_data = chk; e.data = d; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_exp_t e;
    e.addr = a; e.data = d; e.cyc = c;
    wr_q.push_back(e);
  endtask

  // Holds the request until its ack is seen, then drops it in the next cycle.
  task automatic wait_ack(input bit is_ls);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (is_ls ? ls_ack : if_ack) break;
    end
    if (k == 40) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no %s ack in 40 cycles, required one",
               is_ls ? "ls" : "if");
    end
    @(posedge clk);
    #2;
    if (is_ls) ls_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    int t;
    int n0;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
    mem[32'h1000] = 8'h13; mem[32'h1001] = 8'h05;
    mem[32'h1002] = 8'h00; mem[32'h1003] = 8'h00;
    mem[32'h7]    = 8'h80;
    step(3);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("rst_ram_dout", {24'b0, ram_dout}, 32'h0);
    check("rst_if_ack", {31'b0, if_ack}, 32'h0);
    check("rst_ls_ack", {31'b0, ls_ack}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst_n = 1'b1;
    step(2);

    // Word fetch.
    t = cyc;
    exp_ack(1'b0, 1'b1, 32'h0000_0513, t + 6);
    if_addr = 32'h1000; if_req = 1'b1;
    wait_ack(1'b0);
    step(1);

    // Store word races a fetch; store wins, fetch granted after.
    t = cyc;
    exp_wr(32'h20, 8'hEF, t + 1); exp_wr(32'h21, 8'hBE, t + 2);
    exp_wr(32'h22, 8'hAD, t + 3); exp_wr(32'h23, 8'hDE, t + 4);
    exp_ack(1'b1, 1'b0, 32'h0, t + 5);
    exp_ack(1'b0, 1'b1, 32'h5958_5B5A, t + 12);
    ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    fork
      wait_ack(1'b1);
      wait_ack(1'b0);
    join
    ls_we = 1'b0;
    step(1);

    // Byte load, zero-extended.
    t = cyc;
    exp_ack(1'b1, 1'b1, 32'h0000_0080, t + 3);
    ls_size = 2'd0; ls_addr = 32'h7; ls_req = 1'b1;
    wait_ack(1'b1);
    step(1);

    // Flush aborts a fetch; a new fetch is granted the next cycle.
    n0 = if_acks;
    t = cyc;
    if_addr = 32'h300; if_req = 1'b1;
    step(3);
    flush = 1'b1; if_req = 1'b0;
    step(1);
    flush = 1'b0;
    exp_ack(1'b0, 1'b1, 32'h5D5C_5F5E, t + 10);
    if_addr = 32'h404; if_req = 1'b1;
    wait_ack(1'b0);
    check("flush_no_if_ack", if_acks, n0 + 1);
    step(1);

    // Flush has no effect on a store.
    t = cyc;
    exp_wr(32'h40, 8'h34, t + 1); exp_wr(32'h41, 8'h12, t + 2);
    exp_ack(1'b1, 1'b0, 32'h0, t + 3);
    ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h40; ls_wdata = 32'h0000_1234; ls_req = 1'b1;
    flush = 1'b1;
    wait_ack(1'b1);
    flush = 1'b0;
    step(1);

    // Half store across the address wrap, paused for 3 cycles.
    t = cyc;
    exp_wr(32'hFFFF_FFFF, 8'hC3, t + 1);
    exp_wr(32'h0000_0000, 8'hA5, t + 5);
    exp_ack(1'b1, 1'b0, 32'h0, t + 6);
    ls_addr = 32'hFFFF_FFFF; ls_wdata = 32'h0000_A5C3; ls_req = 1'b1;
    step(2);
    rdy = 1'b0;
    step(3);
    rdy = 1'b1;
    wait_ack(1'b1);
    ls_we = 1'b0;
    step(1);

    // Pause mid-fetch: bytes must still assemble correctly.
    exp_ack(1'b0, 1'b1, 32'h0000_0513, -1);
    if_addr = 32'h1000; if_req = 1'b1;
    step(3);
    rdy = 1'b0;
    step(2);
    rdy = 1'b1;
    wait_ack(1'b0);
    step(1);

    // Reset mid-fetch discards the access.
    if_addr = 32'h100; if_req = 1'b1;
    step(3);
    rst_n = 1'b0; if_req = 1'b0;
    step(1);
    check("rst_mid_ram_wr", {31'b0, ram_wr}, 32'h0);
    check("rst_mid_if_ack", {31'b0, if_ack}, 32'h0);
    check("rst_mid_ram_a", ram_a, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    t = cyc;
    exp_ack(1'b0, 1'b1, 32'h5958_5B5A, t + 6);
    if_req = 1'b1;
    wait_ack(1'b0);

    step(3);
    check("ack_queue_empty", ack_q.size(), 32'h0);
    check("wr_queue_empty", wr_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
